// File: rtl/toy_commit_rename_table_if.sv
// Commit / release / restore bundle between the commit stage, freelist and
// speculative RAT on one side and the committed rename table on the other.
interface toy_commit_rename_table_if #(
    parameter int NUM_ARCH   = 32,
    parameter int PHY_W      = 7,
    parameter int COMMIT_CH  = 4,
    parameter int RESTORE_BW = 4
);
    localparam int AW = $clog2(NUM_ARCH);

    logic [COMMIT_CH-1:0]        commit_en;
    logic [COMMIT_CH-1:0]        commit_rd_en;
    logic [COMMIT_CH*AW-1:0]     commit_arch_idx;
    logic [COMMIT_CH*PHY_W-1:0]  commit_phy_idx;
    logic                        commit_stall;
    logic [COMMIT_CH-1:0]        rel_vld;
    logic [COMMIT_CH*PHY_W-1:0]  rel_phy_idx;
    logic                        flush_req;
    logic                        restore_vld;
    logic                        restore_rdy;
    logic [AW-1:0]               restore_base;
    logic [RESTORE_BW*PHY_W-1:0] restore_phy;
    logic                        restore_done;

    modport master (
        output commit_en, commit_rd_en, commit_arch_idx, commit_phy_idx,
        output flush_req, restore_rdy,
        input  commit_stall, rel_vld, rel_phy_idx,
        input  restore_vld, restore_base, restore_phy, restore_done
    );

    modport slave (
        input  commit_en, commit_rd_en, commit_arch_idx, commit_phy_idx,
        input  flush_req, restore_rdy,
        output commit_stall, rel_vld, rel_phy_idx,
        output restore_vld, restore_base, restore_phy, restore_done
    );
endinterface

// File: rtl/toy_commit_rename_table.sv
// Committed rename table: applies up to COMMIT_CH commits per cycle, returns the
// displaced physical ids for release, and streams the whole map back on flush.
module toy_commit_rename_table #(
    parameter int NUM_ARCH   = 32,
    parameter int PHY_W      = 7,
    parameter int COMMIT_CH  = 4,
    parameter int RESTORE_BW = 4,
    parameter int MODE       = 0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    toy_commit_rename_table_if.slave  bus
);
    localparam int AW = $clog2(NUM_ARCH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RESTORE,
        ST_DONE
    } state_e;

    state_e              state_q, state_d;
    logic [AW-1:0]       ptr_q, ptr_d;
    logic [PHY_W-1:0]    table_q [NUM_ARCH];
    logic [PHY_W-1:0]    table_d [NUM_ARCH];
    logic [COMMIT_CH-1:0] rel_vld_q, rel_vld_d;
    logic [PHY_W-1:0]    rel_phy_q [COMMIT_CH];
    logic [PHY_W-1:0]    rel_phy_d [COMMIT_CH];

    logic [COMMIT_CH-1:0] w;
    logic [AW-1:0]       arch [COMMIT_CH];
    logic [PHY_W-1:0]    phy  [COMMIT_CH];
    logic                commit_stall;

    assign commit_stall = (state_q != ST_IDLE);

    // Commits arriving while stalled are dropped; int class never writes x0.
    always_comb begin
        w = '0;
        for (int i = 0; i < COMMIT_CH; i++) begin
            arch[i] = bus.commit_arch_idx[i*AW +: AW];
            phy[i]  = bus.commit_phy_idx[i*PHY_W +: PHY_W];
            w[i]    = bus.commit_en[i] & bus.commit_rd_en[i] & ~commit_stall
                      & ~((MODE == 0) && (arch[i] == '0));
        end
    end

    // NOTE: every variable written here gets a default first, otherwise paths
    // that skip an assignment would infer latches.
    always_comb begin
        table_d = table_q;
        for (int i = 0; i < COMMIT_CH; i++) begin
            if (w[i]) begin
                table_d[arch[i]] = phy[i];
            end
        end
        if (MODE == 0) begin
            table_d[0] = '0;
        end
    end

    // An older channel renaming the same rd displaces the table's entry first,
    // so a younger one frees the older channel's phy, never the live mapping.
    always_comb begin
        rel_vld_d = w;
        for (int i = 0; i < COMMIT_CH; i++) begin
            rel_phy_d[i] = table_q[arch[i]];
            for (int j = 0; j < COMMIT_CH; j++) begin
                if ((j < i) && w[j] && (arch[j] == arch[i])) begin
                    rel_phy_d[i] = phy[j];
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.flush_req) begin
                    state_d = ST_RESTORE;
                    ptr_d   = '0;
                end
            end
            ST_RESTORE: begin
                if (bus.flush_req) begin
                    ptr_d = '0;
                end else if (bus.restore_rdy) begin
                    if (ptr_q == AW'(NUM_ARCH - RESTORE_BW)) begin
                        state_d = ST_DONE;
                    end else begin
                        ptr_d = ptr_q + AW'(RESTORE_BW);
                    end
                end
            end
            ST_DONE: begin
                if (bus.flush_req) begin
                    state_d = ST_RESTORE;
                    ptr_d   = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                ptr_d   = '0;
            end
        endcase
    end

    // NOTE: the table is an explicit flop array rather than a RAM because it
    // must come out of reset holding the identity map.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            ptr_q     <= '0;
            rel_vld_q <= '0;
            for (int i = 0; i < NUM_ARCH; i++) begin
                table_q[i] <= PHY_W'(i);
            end
            for (int i = 0; i < COMMIT_CH; i++) begin
                rel_phy_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            rel_vld_q <= rel_vld_d;
            table_q   <= table_d;
            rel_phy_q <= rel_phy_d;
        end
    end

    always_comb begin
        bus.commit_stall = commit_stall;
        bus.rel_vld      = rel_vld_q;
        bus.restore_vld  = (state_q == ST_RESTORE);
        bus.restore_done = (state_q == ST_DONE);
        bus.restore_base = ptr_q;
        bus.rel_phy_idx  = '0;
        bus.restore_phy  = '0;
        for (int i = 0; i < COMMIT_CH; i++) begin
            bus.rel_phy_idx[i*PHY_W +: PHY_W] = rel_phy_q[i];
        end
        for (int b = 0; b < RESTORE_BW; b++) begin
            bus.restore_phy[b*PHY_W +: PHY_W] = table_q[ptr_q + AW'(b)];
        end
    end

    // Upstream must hold off commits while the table is restoring.
    assert property (@(posedge clk) disable iff (!rst_n)
        !(commit_stall && (|bus.commit_en)));

endmodule
